// File: rtl/jt10_adpcm_pkg.sv
// Shared widths and reciprocal defaults for the JT10 ADPCM interpolating mixers.
package jt10_adpcm_pkg;

    localparam int DEF_RBITS = 8;

    function automatic int acc_w(input int w, input int guard);
        return w + guard;
    endfunction

    function automatic int phase_w(input int ups);
        return (ups < 2) ? 1 : $clog2(ups);
    endfunction

    // RECIP values are round(256/UPS), paired with DEF_RBITS
    function automatic int def_recip(input int ups);
        case (ups)
            2:       return 128;
            3:       return 85;
            4:       return 64;
            5:       return 51;
            6:       return 43;
            7:       return 37;
            8:       return 32;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/jt10_adpcm_interp_acc_sat.sv
// Combinational signed saturator IN_W -> OUT_W with a clip flag; shared by several mixers.
module jt10_adpcm_sat #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic        [OUT_W-1:0] dout,
    output logic                    clip
);

    always_comb begin
        dout = din[OUT_W-1:0];
        clip = 1'b0;
        // In range only when all bits above the output sign bit copy the input sign
        if (din[IN_W-1:OUT_W-1] != {(IN_W-OUT_W+1){din[IN_W-1]}}) begin
            clip = 1'b1;
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/jt10_adpcm_interp_acc.sv
// Time-multiplexed ADPCM channel accumulator with UPS-times linear interpolation and saturation.
// Define JT10_ADPCM_SATCNT_EN to add the sat_cnt clip counter port.
module jt10_adpcm_interp_acc
    import jt10_adpcm_pkg::*;
#(
    parameter int CH    = 6,
    parameter int W     = 16,
    parameter int GUARD = 3,
    parameter int UPS   = 3,
    parameter int RECIP = 85,
    parameter int RBITS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [CH-1:0] cur_ch,
    input  logic          match,
    input  logic          en_sum,
    input  logic [W-1:0]  pcm_in,
    output logic [W-1:0]  pcm_out,
    output logic          out_valid
`ifdef JT10_ADPCM_SATCNT_EN
   ,output logic [7:0]    sat_cnt
`endif
);

    localparam int AW  = acc_w(W, GUARD);
    localparam int PW  = AW + RBITS + 1;
    localparam int PHW = phase_w(UPS);
    localparam logic [PHW-1:0]       LAST_PHASE = PHW'(UPS - 1);
    localparam logic signed [PW-1:0] RECIP_S    = PW'(RECIP);

    logic signed [AW-1:0] acc_q, acc_d, last_q, last_d, step_q, step_d, full_q, full_d;
    logic [PHW-1:0]       phase_q, phase_d;
    logic [W-1:0]         pcm_out_q, pcm_out_d;
    logic                 out_valid_q, out_valid_d;

    logic signed [AW-1:0] ext, sum_done, full_next, step_new;
    logic signed [PW-1:0] diff, prod;
    logic                 round_end, commit, clip;
    logic [W-1:0]         sat_val;
    logic                 unused_bits;

    jt10_adpcm_sat #(.IN_W(AW), .OUT_W(W)) u_sat (
        .din  (full_next),
        .dout (sat_val),
        .clip (clip)
    );

    always_comb begin
        ext       = (match && en_sum) ? {{GUARD{pcm_in[W-1]}}, pcm_in} : '0;
        sum_done  = cur_ch[0] ? ext : acc_q + ext;
        round_end = cen && cur_ch[CH-1];
        commit    = round_end && (phase_q == LAST_PHASE);
        // Full-width difference times reciprocal; taking bits above RBITS is a floor shift
        diff      = {{(PW-AW){sum_done[AW-1]}}, sum_done} - {{(PW-AW){last_q[AW-1]}}, last_q};
        prod      = diff * RECIP_S;
        step_new  = prod[RBITS +: AW];
        full_next = commit ? last_q : full_q + step_q;

        acc_d       = acc_q;
        last_d      = last_q;
        step_d      = step_q;
        full_d      = full_q;
        phase_d     = phase_q;
        pcm_out_d   = pcm_out_q;
        out_valid_d = 1'b0;
        if (cen) begin
            acc_d = sum_done;
        end
        if (round_end) begin
            phase_d     = commit ? '0 : phase_q + PHW'(1);
            full_d      = full_next;
            pcm_out_d   = sat_val;
            out_valid_d = 1'b1;
            if (commit) begin
                step_d = step_new;
                last_d = sum_done;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            last_q      <= '0;
            step_q      <= '0;
            full_q      <= '0;
            phase_q     <= '0;
            pcm_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            last_q      <= last_d;
            step_q      <= step_d;
            full_q      <= full_d;
            phase_q     <= phase_d;
            pcm_out_q   <= pcm_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign pcm_out     = pcm_out_q;
    assign out_valid   = out_valid_q;
    assign unused_bits = ^{prod[PW-1], prod[RBITS-1:0], cur_ch};

`ifdef JT10_ADPCM_SATCNT_EN
    logic [7:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (round_end && clip && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_d = sat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    logic unused_clip;
    assign unused_clip = clip;
`endif

endmodule
